// File: rtl/l2_cache_control.sv
// l2_cache_control: hit/miss sequencing FSM for the 8-way L2 cache datapath
module l2_cache_control #(
  parameter int WAYS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic            mem_resp,
  input  logic [WAYS-1:0] hit,
  input  logic [WAYS-1:0] dirty,
  input  logic [2:0]      lru_way,
  input  logic            pmem_resp,
  output logic            pmem_read,
  output logic            pmem_write,
  output logic [3:0]      pmem_addr_sel,
  output logic            data_in_sel,
  output logic            data_write_en_sel,
  output logic [WAYS-1:0] load_way,
  output logic            set_dirty,
  output logic            clr_dirty,
  output logic            load_lru,
  output logic [2:0]      lru_touch
);
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;
  state_t state, next;
  logic [2:0] victim, hit_way;
  logic req, any_hit;
  assign req = mem_read | mem_write;
  assign any_hit = |hit;
  // Multi-hot hit resolves to the lowest index
  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) hit_way = hit[i] ? 3'(i) : hit_way;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      victim <= '0;
    end else begin
      state <= next;
      if (state == COMPARE && req && !any_hit) victim <= lru_way;
    end
  end
  always_comb begin
    next              = state;
    mem_resp          = 1'b0;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    pmem_addr_sel     = '0;
    data_in_sel       = 1'b0;
    data_write_en_sel = 1'b0;
    load_way          = '0;
    set_dirty         = 1'b0;
    clr_dirty         = 1'b0;
    load_lru          = 1'b0;
    lru_touch         = '0;
    case (state)
      IDLE: next = req ? COMPARE : IDLE;
      COMPARE: begin
        if (!req) next = IDLE;
        else if (any_hit) begin
          next        = IDLE;
          mem_resp    = 1'b1;
          load_lru    = 1'b1;
          lru_touch   = hit_way;
          load_way    = mem_write ? WAYS'(1) << hit_way : '0;
          data_in_sel = mem_write;
          set_dirty   = mem_write;
        end else next = dirty[lru_way] ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 4'(victim) + 4'd1;
        next          = pmem_resp ? FILL : WRITEBACK;
      end
      FILL: begin
        pmem_read         = 1'b1;
        load_way          = pmem_resp ? WAYS'(1) << victim : '0;
        data_write_en_sel = pmem_resp;
        clr_dirty         = pmem_resp;
        next              = pmem_resp ? COMPARE : FILL;
      end
      default: next = IDLE;
    endcase
  end
endmodule
